// File: rtl/pipe_ctrl_pkg.sv
// Shared types and control-vector encodings for the pipeline enable/flush sequencer.
// Control vector bit order: {pc_en, fd_en, fd_flush, de_en, de_flush, em_en, em_flush, mw_en}.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MC_BUSY,
        MEM_WAIT
    } state_e;

    localparam int unsigned CTRL_W = 8;

    localparam int unsigned BIT_PC_EN    = 7;
    localparam int unsigned BIT_FD_EN    = 6;
    localparam int unsigned BIT_FD_FLUSH = 5;
    localparam int unsigned BIT_DE_EN    = 4;
    localparam int unsigned BIT_DE_FLUSH = 3;
    localparam int unsigned BIT_EM_EN    = 2;
    localparam int unsigned BIT_EM_FLUSH = 1;
    localparam int unsigned BIT_MW_EN    = 0;

    localparam logic [CTRL_W-1:0] CTRL_DEFAULT    = 8'b1101_0101;
    localparam logic [CTRL_W-1:0] CTRL_FREEZE_ALL = 8'b0000_0000;
    localparam logic [CTRL_W-1:0] CTRL_MC_FREEZE  = 8'b0000_0111;
    localparam logic [CTRL_W-1:0] CTRL_BR_FLUSH   = 8'b1111_1101;
    localparam logic [CTRL_W-1:0] CTRL_LOAD_USE   = 8'b0001_1101;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; stops at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (clr) begin
            q <= '0;
        end else if (en && (q != '1)) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/pipeline_stall_sequencer.sv
// Merges load-use stalls, branch flushes, multi-cycle EXE ops and data-memory waits into one
// set of per-stage enables/flushes, with saturating stall/flush performance counters.
module pipeline_stall_sequencer
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MC_LAT = 4,
    parameter int unsigned CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hz_stall,
    input  logic             br_flush,
    input  logic             mc_start,
    input  logic             mem_req,
    input  logic             mem_ack,
    output logic             PC_EN_IF,
    output logic             reg_FD_EN,
    output logic             reg_FD_flush,
    output logic             reg_DE_EN,
    output logic             reg_DE_flush,
    output logic             reg_EM_EN,
    output logic             reg_EM_flush,
    output logic             reg_MW_EN,
    output logic             mc_done,
    output logic             busy,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam int unsigned CW = (MC_LAT > 2) ? $clog2(MC_LAT) : 1;

    state_e              state_q, state_d, ret_q, ret_d, eff_state;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [CTRL_W-1:0]   ctrl;
    logic                mem_pend;
    logic                mc_done_c;
    logic                br_applied;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ret_q   <= IDLE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ret_q   <= ret_d;
        end
    end

    always_comb begin
        ctrl       = CTRL_DEFAULT;
        mc_done_c  = 1'b0;
        br_applied = 1'b0;
        state_d    = state_q;
        cnt_d      = cnt_q;
        ret_d      = ret_q;
        eff_state  = state_q;
        mem_pend   = mem_req && !mem_ack;

        // An acknowledged wait cycle is decoded as the saved state with memory already done.
        if (state_q == MEM_WAIT) begin
            eff_state = ret_q;
            mem_pend  = 1'b0;
        end

        if ((state_q == MEM_WAIT) && !mem_ack) begin
            ctrl = CTRL_FREEZE_ALL;
        end else begin
            case (eff_state)
                IDLE: begin
                    state_d = IDLE;
                    if (mem_pend) begin
                        ctrl    = CTRL_FREEZE_ALL;
                        ret_d   = IDLE;
                        state_d = MEM_WAIT;
                    end else if (mc_start) begin
                        ctrl    = CTRL_MC_FREEZE;
                        cnt_d   = CW'(MC_LAT - 2);
                        state_d = MC_BUSY;
                    end else if (br_flush) begin
                        ctrl       = CTRL_BR_FLUSH;
                        br_applied = 1'b1;
                    end else if (hz_stall) begin
                        ctrl = CTRL_LOAD_USE;
                    end
                end
                MC_BUSY: begin
                    state_d = MC_BUSY;
                    if (mem_pend) begin
                        ctrl    = CTRL_FREEZE_ALL;
                        ret_d   = MC_BUSY;
                        state_d = MEM_WAIT;
                    end else if (cnt_q == '0) begin
                        mc_done_c = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        ctrl  = CTRL_MC_FREEZE;
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        if (rst) begin
            ctrl       = CTRL_DEFAULT;
            mc_done_c  = 1'b0;
            br_applied = 1'b0;
        end
    end

    assign PC_EN_IF     = ctrl[BIT_PC_EN];
    assign reg_FD_EN    = ctrl[BIT_FD_EN];
    assign reg_FD_flush = ctrl[BIT_FD_FLUSH];
    assign reg_DE_EN    = ctrl[BIT_DE_EN];
    assign reg_DE_flush = ctrl[BIT_DE_FLUSH];
    assign reg_EM_EN    = ctrl[BIT_EM_EN];
    assign reg_EM_flush = ctrl[BIT_EM_FLUSH];
    assign reg_MW_EN    = ctrl[BIT_MW_EN];
    assign mc_done      = mc_done_c;
    assign busy         = (state_q != IDLE) && !rst;

    sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk(clk),
        .en (!ctrl[BIT_PC_EN]),
        .clr(rst),
        .q  (stall_cycles)
    );

    sat_counter #(
        .W(CNT_W)
    ) u_flush_cnt (
        .clk(clk),
        .en (br_applied),
        .clr(rst),
        .q  (flush_count)
    );

endmodule
